// File: rtl/framebuffer_pkg.sv
// Shared defaults and FSM state type for the double-buffered framebuffer.
// Pure declarations: no logic, no latency, no flow control.
package framebuffer_pkg;
  localparam int LARGURA_PAD  = 640;
  localparam int ALTURA_PAD   = 480;
  localparam int BITS_COR_PAD = 9;

  typedef enum logic {
    OCIOSO   = 1'b0,
    LIMPANDO = 1'b1
  } estado_t;
endpackage

// File: rtl/framebuffer_duplo_memoria_banco.sv
// Simple dual-port bank: one synchronous write, one synchronous read (1 cycle).
// No backpressure; read data register holds its value when rd_en_i is low.
module memoria_banco
  import framebuffer_pkg::*;
#(
  parameter int PROF = 16,
  parameter int LARG = 9,
  parameter int IW   = $clog2(PROF)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [IW-1:0]   wr_end_i,
  input  logic [LARG-1:0] wr_dat_i,
  input  logic            rd_en_i,
  input  logic [IW-1:0]   rd_end_i,
  output logic [LARG-1:0] rd_dat_o
);
  logic [LARG-1:0] mem [PROF];
  logic [LARG-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[wr_end_i] <= wr_dat_i;
    if (rd_en_i) rd_dat_q <= mem[rd_end_i];
  end

  assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/framebuffer_duplo.sv
// Double-buffered framebuffer: reads from the front bank (1-cycle latency), writes/clears the back bank.
// wr_ready drops while a clear sweeps the back bank or reset is asserted; the read port never stalls.
module framebuffer_duplo
  import framebuffer_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PAD,
  parameter int ALTURA   = ALTURA_PAD,
  parameter int BITS_COR = BITS_COR_PAD,
  parameter int AW       = $clog2(LARGURA * ALTURA)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AW-1:0]       wr_endereco,
  input  logic [BITS_COR-1:0] wr_dado,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_endereco,
  output logic [BITS_COR-1:0] rd_dado,
  output logic                rd_valid,
  input  logic                swap_req,
  input  logic                clear_req,
  input  logic [BITS_COR-1:0] clear_cor,
  output logic                ocupado,
  output logic                banco_frente
);
  localparam int PROF = LARGURA * ALTURA;
  localparam int IW   = $clog2(PROF);
  localparam logic [AW:0]   LIMITE = (AW + 1)'(PROF);
  localparam logic [IW-1:0] ULTIMO = IW'(PROF - 1);

  estado_t             estado_q, estado_d;
  logic                banco_q, banco_d;
  logic                pend_q, pend_d;
  logic [IW-1:0]       cont_q, cont_d;
  logic [BITS_COR-1:0] cor_q, cor_d;

  logic                rd_valid_q, rd_sel_q, rd_zero_q;
  logic                wr_dentro, rd_dentro;
  logic                we_tras;
  logic [IW-1:0]       end_tras;
  logic [BITS_COR-1:0] dat_tras;
  logic [BITS_COR-1:0] rd_dat0, rd_dat1;

  // Out-of-range addresses are compared at full width so they never alias into the bank.
  assign wr_dentro = {1'b0, wr_endereco} < LIMITE;
  assign rd_dentro = {1'b0, rd_endereco} < LIMITE;

  assign wr_ready     = !reset && (estado_q == OCIOSO);
  assign ocupado      = (estado_q == LIMPANDO);
  assign banco_frente = banco_q;

  always_comb begin
    estado_d = estado_q;
    banco_d  = banco_q;
    pend_d   = pend_q;
    cont_d   = cont_q;
    cor_d    = cor_q;
    case (estado_q)
      OCIOSO: begin
        if (swap_req) banco_d = !banco_q;
        if (clear_req) begin
          cor_d    = clear_cor;
          cont_d   = '0;
          estado_d = LIMPANDO;
        end
      end
      LIMPANDO: begin
        if (swap_req) pend_d = 1'b1;
        if (cont_q == ULTIMO) begin
          estado_d = OCIOSO;
          pend_d   = 1'b0;
          if (pend_q || swap_req) banco_d = !banco_q;
        end else begin
          cont_d = cont_q + IW'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      banco_q  <= 1'b0;
      pend_q   <= 1'b0;
      cont_q   <= '0;
      cor_q    <= '0;
    end else begin
      estado_q <= estado_d;
      banco_q  <= banco_d;
      pend_q   <= pend_d;
      cont_q   <= cont_d;
      cor_q    <= cor_d;
    end
  end

  // Single back-bank write port shared by the clear sweep and accepted pixel writes.
  always_comb begin
    we_tras  = 1'b0;
    end_tras = wr_endereco[IW-1:0];
    dat_tras = wr_dado;
    if (!reset) begin
      if (estado_q == LIMPANDO) begin
        we_tras  = 1'b1;
        end_tras = cont_q;
        dat_tras = cor_q;
      end else begin
        we_tras = wr_valid && wr_ready && wr_dentro;
      end
    end
  end

  memoria_banco #(.PROF(PROF), .LARG(BITS_COR)) u_banco0 (
    .clk      (clk),
    .we_i     (we_tras && banco_q),
    .wr_end_i (end_tras),
    .wr_dat_i (dat_tras),
    .rd_en_i  (rd_en && rd_dentro),
    .rd_end_i (rd_endereco[IW-1:0]),
    .rd_dat_o (rd_dat0)
  );

  memoria_banco #(.PROF(PROF), .LARG(BITS_COR)) u_banco1 (
    .clk      (clk),
    .we_i     (we_tras && !banco_q),
    .wr_end_i (end_tras),
    .wr_dat_i (dat_tras),
    .rd_en_i  (rd_en && rd_dentro),
    .rd_end_i (rd_endereco[IW-1:0]),
    .rd_dat_o (rd_dat1)
  );

  // Bank select and zero flag are captured only on rd_en, so rd_dado holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_sel_q  <= banco_q;
        rd_zero_q <= !rd_dentro;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_dado  = rd_zero_q ? '0 : (rd_sel_q ? rd_dat1 : rd_dat0);
endmodule

// File: tb/tb_framebuffer_duplo.sv
// Randomized bench for framebuffer_duplo (4x2 frame, 4-bit address so address 8 is reachable).
// Reference model keeps both banks as plain arrays plus the current front index.
module tb_framebuffer_duplo;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_endereco = '0;
  logic [8:0] wr_dado = '0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_endereco = '0;
  logic [8:0] rd_dado;
  logic       rd_valid;
  logic       swap_req = 1'b0;
  logic       clear_req = 1'b0;
  logic [8:0] clear_cor = '0;
  logic       ocupado;
  logic       banco_frente;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] mem_m [2][N];
  bit         known_m [2][N];
  int         frente_m = 0;

  framebuffer_duplo #(.LARGURA(4), .ALTURA(2), .BITS_COR(9), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_endereco(wr_endereco), .wr_dado(wr_dado),
    .rd_en(rd_en), .rd_endereco(rd_endereco), .rd_dado(rd_dado), .rd_valid(rd_valid),
    .swap_req(swap_req), .clear_req(clear_req), .clear_cor(clear_cor),
    .ocupado(ocupado), .banco_frente(banco_frente)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ref_rd(int b, int a);
    return (a < N) ? mem_m[b][a] : 9'h000;
  endfunction

  function automatic bit ref_ok(int b, int a);
    return (a >= N) || known_m[b][a];
  endfunction

  task automatic fill_m(int b, logic [8:0] c);
    for (int i = 0; i < N; i++) begin
      mem_m[b][i] = c;
      known_m[b][i] = 1'b1;
    end
  endtask

  task automatic do_write(int a, logic [8:0] d);
    wr_valid = 1'b1; wr_endereco = a[3:0]; wr_dado = d;
    tick();
    wr_valid = 1'b0;
    if (a < N) begin
      mem_m[1-frente_m][a] = d;
      known_m[1-frente_m][a] = 1'b1;
    end
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frente_m = 1 - frente_m;
  endtask

  task automatic do_read(int a);
    rd_en = 1'b1; rd_endereco = a[3:0];
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
    vectors++; if (banco_frente !== 1'b0) begin miscompares++; $display("FAIL reset_banco got %b exp 0", banco_frente); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    vectors++; if (rd_dado !== 9'h000) begin miscompares++; $display("FAIL reset_rd_dado got %h exp 000", rd_dado); end
    vectors++; if (ocupado !== 1'b0) begin miscompares++; $display("FAIL reset_ocupado got %b exp 0", ocupado); end
    reset = 1'b0;
    #1;
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_wr_ready got %b exp 1", wr_ready); end
    frente_m = 0;
  endtask

  task automatic init_banks();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) do_write(i, 9'($urandom));
      do_swap();
    end
  endtask

  task automatic test_basic();
    do_write(5, 9'h1FF);
    do_swap();
    do_read(5);
    vectors++; if (rd_dado !== 9'h1FF) begin miscompares++; $display("FAIL basic_rd_dado got %h exp 1ff", rd_dado); end
    vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL basic_rd_valid got %b exp 1", rd_valid); end
    vectors++; if (banco_frente !== 1'b1) begin miscompares++; $display("FAIL basic_banco got %b exp 1", banco_frente); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] last = '0;
    bit have_last = 1'b0;
    for (int it = 0; it < 80; it++) begin
      bit do_wr = 1'($urandom);
      bit do_rd = 1'($urandom);
      bit do_sw = ($urandom_range(0, 4) == 0);
      int wa = $urandom_range(0, 9);
      int ra = $urandom_range(0, 9);
      logic [8:0] wd = 9'($urandom);
      logic [8:0] exp_d = ref_rd(frente_m, ra);
      bit ok = ref_ok(frente_m, ra);
      wr_valid = do_wr; wr_endereco = wa[3:0]; wr_dado = wd;
      rd_en = do_rd; rd_endereco = ra[3:0]; swap_req = do_sw;
      tick();
      wr_valid = 1'b0; rd_en = 1'b0; swap_req = 1'b0;
      if (do_rd) begin
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_rd_valid it=%0d got %b exp 1", it, rd_valid); end
        if (ok) begin
          vectors++; if (rd_dado !== exp_d) begin miscompares++; $display("FAIL b2b_rd_dado it=%0d a=%0d got %h exp %h", it, ra, rd_dado, exp_d); end
          last = exp_d; have_last = 1'b1;
        end else have_last = 1'b0;
      end else begin
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_rd_idle it=%0d got %b exp 0", it, rd_valid); end
        if (have_last) begin
          vectors++; if (rd_dado !== last) begin miscompares++; $display("FAIL b2b_rd_hold it=%0d got %h exp %h", it, rd_dado, last); end
        end
      end
      if (do_wr && wa < N) begin
        mem_m[1-frente_m][wa] = wd;
        known_m[1-frente_m][wa] = 1'b1;
      end
      if (do_sw) frente_m = 1 - frente_m;
      vectors++; if (banco_frente !== frente_m[0]) begin miscompares++; $display("FAIL b2b_banco it=%0d got %b exp %0d", it, banco_frente, frente_m); end
    end
  endtask

  task automatic test_clear();
    int n = 0;
    int b = 1 - frente_m;
    clear_cor = 9'h038; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    while (ocupado === 1'b1 && n < 50) begin
      int ra = $urandom_range(0, N - 1);
      vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL clear_wr_ready n=%0d got %b exp 0", n, wr_ready); end
      clear_req = (n == 2); clear_cor = (n == 2) ? 9'h1C7 : 9'h038;
      rd_en = 1'b1; rd_endereco = ra[3:0];
      tick();
      rd_en = 1'b0; clear_req = 1'b0;
      if (ref_ok(frente_m, ra)) begin
        vectors++; if (rd_dado !== ref_rd(frente_m, ra)) begin miscompares++; $display("FAIL clear_front_rd a=%0d got %h exp %h", ra, rd_dado, ref_rd(frente_m, ra)); end
      end
      n++;
    end
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL clear_cycles got %0d exp 8", n); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL clear_end_wr_ready got %b exp 1", wr_ready); end
    fill_m(b, 9'h038);
    do_swap();
    for (int i = 0; i < N; i++) begin
      do_read(i);
      vectors++; if (rd_dado !== 9'h038) begin miscompares++; $display("FAIL clear_readback a=%0d got %h exp 038", i, rd_dado); end
    end
  endtask

  task automatic test_swap_during_clear();
    int n = 0;
    int b0 = frente_m;
    logic [8:0] cor = 9'($urandom);
    clear_cor = cor; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    fill_m(1 - b0, cor);
    while (ocupado === 1'b1 && n < 50) begin
      vectors++; if (banco_frente !== b0[0]) begin miscompares++; $display("FAIL pend_banco_early n=%0d got %b exp %0d", n, banco_frente, b0); end
      swap_req = (n == 3 || n == 5);
      tick();
      swap_req = 1'b0;
      n++;
    end
    frente_m = 1 - b0;
    vectors++; if (banco_frente !== frente_m[0]) begin miscompares++; $display("FAIL pend_banco_end got %b exp %0d", banco_frente, frente_m); end
    tick(); tick();
    vectors++; if (banco_frente !== frente_m[0]) begin miscompares++; $display("FAIL pend_banco_once got %b exp %0d", banco_frente, frente_m); end
    for (int i = 0; i < N; i++) begin
      do_read(i);
      vectors++; if (rd_dado !== cor) begin miscompares++; $display("FAIL pend_readback a=%0d got %h exp %h", i, rd_dado, cor); end
    end
  endtask

  task automatic test_out_of_range();
    for (int a = N; a < 16; a += 7) begin
      do_read(a);
      vectors++; if (rd_dado !== 9'h000) begin miscompares++; $display("FAIL oor_rd_dado a=%0d got %h exp 000", a, rd_dado); end
      vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL oor_rd_valid a=%0d got %b exp 1", a, rd_valid); end
    end
    do_write(8, 9'h1AA);
    do_write(12, 9'h155);
    for (int k = 0; k < 2; k++) begin
      do_swap();
      for (int i = 0; i < N; i++) begin
        do_read(i);
        if (ref_ok(frente_m, i)) begin
          vectors++; if (rd_dado !== ref_rd(frente_m, i)) begin miscompares++; $display("FAIL oor_bank_intact b=%0d a=%0d got %h exp %h", frente_m, i, rd_dado, ref_rd(frente_m, i)); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int b;
    logic [8:0] cor = 9'($urandom);
    if (frente_m == 0) do_swap();
    b = 1 - frente_m;
    clear_cor = cor; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    vectors++; if (ocupado !== 1'b0) begin miscompares++; $display("FAIL rstmid_ocupado got %b exp 0", ocupado); end
    vectors++; if (banco_frente !== 1'b0) begin miscompares++; $display("FAIL rstmid_banco got %b exp 0", banco_frente); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_rd_valid got %b exp 0", rd_valid); end
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_wr_ready got %b exp 0", wr_ready); end
    reset = 1'b0;
    #1;
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_wr_ready_after got %b exp 1", wr_ready); end
    frente_m = 0;
    for (int i = 0; i < 3; i++) mem_m[b][i] = cor;
    known_m[b][3] = 1'b0;
    tick();
    vectors++; if (ocupado !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_restart got %b exp 0", ocupado); end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        do_read(i);
        if (ref_ok(frente_m, i)) begin
          vectors++; if (rd_dado !== ref_rd(frente_m, i)) begin miscompares++; $display("FAIL rstmid_mem b=%0d a=%0d got %h exp %h", frente_m, i, rd_dado, ref_rd(frente_m, i)); end
        end
      end
      do_swap();
    end
  endtask

  task automatic test_swap_clear_same();
    int n = 0;
    int b0 = frente_m;
    int a = $urandom_range(0, N - 1);
    logic [8:0] d = 9'($urandom);
    logic [8:0] cor = 9'($urandom);
    swap_req = 1'b1; clear_req = 1'b1; clear_cor = cor;
    wr_valid = 1'b1; wr_endereco = a[3:0]; wr_dado = d;
    tick();
    swap_req = 1'b0; clear_req = 1'b0; wr_valid = 1'b0;
    mem_m[1-b0][a] = d; known_m[1-b0][a] = 1'b1;
    frente_m = 1 - b0;
    fill_m(b0, cor);
    vectors++; if (banco_frente !== frente_m[0]) begin miscompares++; $display("FAIL sc_banco got %b exp %0d", banco_frente, frente_m); end
    vectors++; if (ocupado !== 1'b1) begin miscompares++; $display("FAIL sc_ocupado got %b exp 1", ocupado); end
    while (ocupado === 1'b1 && n < 50) begin
      int ra = $urandom_range(0, N - 1);
      rd_en = 1'b1; rd_endereco = ra[3:0];
      tick();
      rd_en = 1'b0;
      if (ref_ok(frente_m, ra)) begin
        vectors++; if (rd_dado !== ref_rd(frente_m, ra)) begin miscompares++; $display("FAIL sc_front_rd a=%0d got %h exp %h", ra, rd_dado, ref_rd(frente_m, ra)); end
      end
      n++;
    end
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL sc_cycles got %0d exp 8", n); end
    for (int k = 0; k < 2; k++) begin
      do_swap();
      for (int i = 0; i < N; i++) begin
        do_read(i);
        if (ref_ok(frente_m, i)) begin
          vectors++; if (rd_dado !== ref_rd(frente_m, i)) begin miscompares++; $display("FAIL sc_readback b=%0d a=%0d got %h exp %h", frente_m, i, rd_dado, ref_rd(frente_m, i)); end
        end
      end
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) begin
        mem_m[b][i] = '0;
        known_m[b][i] = 1'b0;
      end
    test_reset();
    init_banks();
    test_basic();
    test_back_to_back();
    test_clear();
    test_swap_during_clear();
    test_out_of_range();
    test_reset_mid_clear();
    test_swap_clear_same();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/framebuffer_duplo.md
FRAMEBUFFER_DUPLO -- requirements
Module: framebuffer_duplo

Interface
REQ-001 Parameter LARGURA, 640, pixels per line.
REQ-002 Parameter ALTURA, 480, lines per frame.
REQ-003 Parameter BITS_COR, 9, pixel width in bits (3R/3G/3B at the default).
REQ-004 Parameter AW, $clog2(LARGURA*ALTURA), pixel address width (19 at the default).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  reset, synchronous and active-high.
REQ-007 wr_valid  in  1  write request to the back bank.
REQ-008 wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-009 wr_endereco  in  AW  write pixel address.
REQ-010 wr_dado  in  BITS_COR  write pixel value.
REQ-011 rd_en  in  1  read request from the front bank.
REQ-012 rd_endereco  in  AW  read pixel address.
REQ-013 rd_dado  out  BITS_COR  read pixel value.
REQ-014 rd_valid  out  1  rd_dado valid this cycle.
REQ-015 swap_req  in  1  one-cycle pulse (vsync) that exchanges front and back banks.
REQ-016 clear_req  in  1  one-cycle pulse that fills the whole back bank with clear_cor.
REQ-017 clear_cor  in  BITS_COR  fill colour, sampled when clear_req is accepted.
REQ-018 ocupado  out  1  high while a clear is running.
REQ-019 banco_frente  out  1  index (0/1) of the bank the read port serves.

Function
REQ-020 Two banks of LARGURA*ALTURA words each; reads always target banco_frente and writes target !banco_frente, so there is no read/write hazard.
REQ-021 Read latency is 1 cycle: rd_en at edge N gives rd_dado and rd_valid=1 after edge N+1; rd_valid=0 when rd_en=0, and rd_dado then holds its last value.
REQ-022 The read bank is the banco_frente value before any swap taking effect on the same edge.
REQ-023 Address >= LARGURA*ALTURA: the write is accepted but discarded, and the read returns rd_dado=0 with rd_valid=1.
REQ-024 FSM states:
  - OCIOSO: wr_ready=1, ocupado=0.
  - LIMPANDO: wr_ready=0, ocupado=1; a counter writes the latched colour to back-bank addresses 0..LARGURA*ALTURA-1, one per cycle, so a clear lasts exactly LARGURA*ALTURA cycles; then the FSM returns to OCIOSO.
REQ-025 OCIOSO + clear_req: latch clear_cor, reset the counter to 0, go to LIMPANDO on the next edge; a write accepted in that same cycle is performed.
REQ-026 clear_req in LIMPANDO is ignored (no restart, no queueing).
REQ-027 swap_req in OCIOSO toggles banco_frente on that edge.
REQ-028 swap_req in LIMPANDO is latched as pending; banco_frente toggles on the edge the FSM returns to OCIOSO; several pulses still give one swap.
REQ-029 swap_req and clear_req together in OCIOSO: the swap happens first, and the clear fills the new back bank, which is the previous front bank.
REQ-030 The read port keeps running during LIMPANDO.

Reset
REQ-031 While reset=1 at an edge:
  - FSM goes to OCIOSO; banco_frente=0; rd_dado=0; rd_valid=0; ocupado=0.
  - pending swap is cleared; clear counter=0.
  - wr_ready=0 during the reset cycle.
REQ-032 Reset during LIMPANDO aborts the clear; already written pixels keep their value.
REQ-033 Reset does not initialise memory contents.

Structure
REQ-034 Package framebuffer_pkg holds the LARGURA/ALTURA/BITS_COR defaults and the FSM state type (OCIOSO, LIMPANDO).
REQ-035 One sub-module, memoria_banco: simple dual-port RAM with 1 synchronous write and 1 synchronous read, parametrised by depth and width, instantiated twice.

Verification
REQ-036 Write 0x1FF to address 5, swap_req, rd_en at address 5 -> rd_dado=0x1FF and rd_valid=1 one cycle later; banco_frente=1.
REQ-037 clear_req with clear_cor=0x038 (LARGURA=4, ALTURA=2) -> ocupado=1 and wr_ready=0 for exactly 8 cycles; after a swap, all 8 addresses read 0x038.
REQ-038 swap_req 3 cycles into a clear -> banco_frente unchanged until the clear ends, then toggles exactly once.
REQ-039 rd_en at address LARGURA*ALTURA -> rd_dado=0, rd_valid=1; a write to that address leaves both banks unchanged.
REQ-040 reset asserted mid-clear -> next cycle OCIOSO, banco_frente=0, rd_valid=0, ocupado=0; wr_ready=1 the cycle after reset drops.
REQ-041 swap_req and clear_req in the same cycle from OCIOSO -> banco_frente toggles, and the old front bank reads back clear_cor after a second swap.
